// File: rtl/tlb_walker_pkg.sv
// Shared types and constants for the TLB page-table walker.
package tlb_walker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_INSERT,
    ST_FAULT,
    ST_DRAIN,
    ST_SHUT
  } walk_state_e;

  localparam int PTE_VALID_BIT = 0;
  localparam int PTE_BYTES     = 8;
  localparam int PTE_OFF_W     = $clog2(PTE_BYTES);

  // A single-level table still needs a one-bit level register.
  function automatic int lvl_width(input int levels);
    return (levels > 1) ? $clog2(levels) : 1;
  endfunction

endpackage

// File: rtl/tlb_walker_ptw_index_sel.sv
// Selects the per-level VA index and turns it into a PTE byte offset.
module ptw_index_sel
  import tlb_walker_pkg::*;
#(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SIDX   = 9,
  parameter int LEVELS = 4,
  parameter int LVL_W  = lvl_width(LEVELS)
) (
  input  logic [SADDR-1:0] va,
  input  logic [LVL_W-1:0] level,
  output logic [SIDX-1:0]  idx,
  output logic [SADDR-1:0] offset
);

  always_comb begin
    idx    = SIDX'(va >> (SPAGE + SIDX * int'(level)));
    offset = '0;
    offset[SIDX+PTE_OFF_W-1:0] = {idx, {PTE_OFF_W{1'b0}}};
  end

endmodule

// File: rtl/tlb_walker.sv
// Radix page-table walker between the TLB miss output and its insert port,
// with flush sequencing so a shutdown never overlaps an outstanding PTE read.
module tlb_walker
  import tlb_walker_pkg::*;
#(
  parameter int SADDR  = 64,
  parameter int SPAGE  = 12,
  parameter int SPCID  = 12,
  parameter int LEVELS = 4,
  parameter int SIDX   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             miss,
  input  logic [SADDR-1:0] miss_va,
  input  logic [SPCID-1:0] miss_pcid,
  input  logic [SADDR-1:0] root_pa,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [SADDR-1:0] mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [63:0]      mem_resp_data,
  output logic             insert_valid,
  output logic [SADDR-1:0] insert_va,
  output logic [SADDR-1:0] insert_pa,
  output logic [SPCID-1:0] insert_pcid,
  output logic             shutdown,
  output logic             flush_done,
  output logic             fault,
  output logic             busy
);

  localparam int              LVL_W   = lvl_width(LEVELS);
  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(LEVELS - 1);

  walk_state_e      state, state_d;
  logic [SADDR-1:0] va_q;
  logic [SPCID-1:0] pcid_q;
  logic [LVL_W-1:0] level_q;
  logic [SADDR-1:0] sel_va, sel_base, pte_base, offset;
  logic [LVL_W-1:0] sel_level;
  logic [SIDX-1:0]  idx;
  logic             pte_valid, last_level, load_req, load_insert;
  logic             unused_bits;

  assign pte_valid   = mem_resp_data[PTE_VALID_BIT];
  assign pte_base    = {mem_resp_data[SADDR-1:SPAGE], {SPAGE{1'b0}}};
  assign last_level  = (level_q == '0);
  assign unused_bits = ^{mem_resp_data[SPAGE-1:1], idx};

  // From IDLE the first request indexes the root; afterwards the next level.
  assign sel_va    = (state == ST_IDLE) ? miss_va : va_q;
  assign sel_level = (state == ST_IDLE) ? TOP_LVL : (level_q - LVL_W'(1));
  assign sel_base  = (state == ST_IDLE) ? root_pa : pte_base;

  ptw_index_sel #(
    .SADDR (SADDR),
    .SPAGE (SPAGE),
    .SIDX  (SIDX),
    .LEVELS(LEVELS),
    .LVL_W (LVL_W)
  ) u_index_sel (
    .va    (sel_va),
    .level (sel_level),
    .idx   (idx),
    .offset(offset)
  );

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (flush)     state_d = ST_SHUT;
        else if (miss) state_d = ST_REQ;
      end
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      // A response arriving together with flush is the one a drain would wait for.
      ST_WAIT: begin
        if (mem_resp_valid) begin
          if (flush)           state_d = ST_SHUT;
          else if (!pte_valid) state_d = ST_FAULT;
          else if (last_level) state_d = ST_INSERT;
          else                 state_d = ST_REQ;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (mem_resp_valid) state_d = ST_SHUT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign load_req    = (state_d == ST_REQ) && ((state == ST_IDLE) || (state == ST_WAIT));
  assign load_insert = (state == ST_WAIT) && (state_d == ST_INSERT);

  assign mem_req_valid = (state == ST_REQ);
  assign insert_valid  = (state == ST_INSERT);
  assign fault         = (state == ST_FAULT);
  assign shutdown      = (state == ST_SHUT);
  assign flush_done    = (state == ST_SHUT);
  assign busy          = (state != ST_IDLE);

  // p0: state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      mem_req_addr <= '0;
      insert_va    <= '0;
      insert_pa    <= '0;
      insert_pcid  <= '0;
    end else begin
      state <= state_d;
      if (load_req) mem_req_addr <= sel_base + offset;
      if (load_insert) begin
        insert_va   <= va_q;
        insert_pa   <= {mem_resp_data[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
        insert_pcid <= pcid_q;
      end
    end
  end

  // p0: walk context, only meaningful while busy
  always_ff @(posedge clk) begin
    if ((state == ST_IDLE) && (state_d == ST_REQ)) begin
      va_q    <= miss_va;
      pcid_q  <= miss_pcid;
      level_q <= TOP_LVL;
    end else if (load_req) begin
      level_q <= sel_level;
    end
  end

endmodule

// File: tb/tb_tlb_walker.sv
// Randomised bench for tlb_walker against a page-table reference model.
module tb_tlb_walker;
  localparam int SADDR  = 64;
  localparam int SPAGE  = 12;
  localparam int SPCID  = 12;
  localparam int LEVELS = 4;
  localparam int SIDX   = 9;

  logic              clk = 1'b0;
  logic              rst, miss, flush, mem_req_ready, mem_resp_valid;
  logic [SADDR-1:0]  miss_va, root_pa;
  logic [SPCID-1:0]  miss_pcid;
  logic [63:0]       mem_resp_data;
  logic              mem_req_valid, insert_valid, shutdown, flush_done, fault, busy;
  logic [SADDR-1:0]  mem_req_addr, insert_va, insert_pa;
  logic [SPCID-1:0]  insert_pcid;

  int checks = 0;
  int errors = 0;
  logic [51:0] ppn_tab [LEVELS];

  tlb_walker #(.SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .LEVELS(LEVELS), .SIDX(SIDX)) dut (
    .clk(clk), .rst(rst), .miss(miss), .miss_va(miss_va), .miss_pcid(miss_pcid),
    .root_pa(root_pa), .flush(flush), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .insert_valid(insert_valid), .insert_va(insert_va), .insert_pa(insert_pa),
    .insert_pcid(insert_pcid), .shutdown(shutdown), .flush_done(flush_done),
    .fault(fault), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pte_of(input int lvl, input int fault_lvl);
    logic [63:0] p;
    p       = {ppn_tab[lvl], 12'h000};
    p[11:1] = 11'($urandom);
    p[0]    = (lvl != fault_lvl);
    return p;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // One miss, walked with a fixed per-level stall and response delay.
  // flush_req>0 raises flush while that request's response is outstanding;
  // rst_at>=0 pulses reset in that cycle and then injects a stray response.
  task automatic run_walk(input logic [63:0] root, input logic [63:0] va,
                          input logic [11:0] pcid, input int fault_lvl,
                          input int stall, input int rdelay,
                          input int flush_req, input int rst_at);
    int cyc, nreq, nreq_at_rst, stall_left, resp_wait, pend_lvl, lvl, span;
    int ins_cyc, flt_cyc, shut_cyc, flush_resp_cyc, n_ins, n_flt, n_shut;
    bit outstanding, in_req, flush_up;
    logic [63:0] exp_addr, base;
    nreq = 0; nreq_at_rst = 0; stall_left = 0; resp_wait = 0; pend_lvl = 0; lvl = 0;
    ins_cyc = -1; flt_cyc = -1; shut_cyc = -1; flush_resp_cyc = -1;
    n_ins = 0; n_flt = 0; n_shut = 0;
    outstanding = 0; in_req = 0; flush_up = 0; exp_addr = '0;
    span = stall + rdelay + 2;

    miss_va = va; miss_pcid = pcid; root_pa = root; miss = 1'b1;
    step();
    miss = 1'b0; root_pa = rand64();
    cyc = 1;
    for (int k = 0; k < LEVELS * span + 12; k++) begin
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        chk("rst_pulses", {58'b0, mem_req_valid, insert_valid, shutdown, flush_done, fault, busy}, 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_ins_va", insert_va, 64'd0);
        chk("rst_ins_pa", insert_pa, 64'd0);
        chk("rst_ins_pcid", 64'(insert_pcid), 64'd0);
        outstanding = 1; resp_wait = 1; pend_lvl = 0;
      end
      if (insert_valid) begin
        n_ins++; ins_cyc = cyc;
        chk("ins_va", insert_va, va);
        chk("ins_pa", insert_pa, {ppn_tab[0], va[11:0]});
        chk("ins_pcid", 64'(insert_pcid), 64'(pcid));
      end
      if (fault) begin n_flt++; flt_cyc = cyc; end
      if (shutdown) begin
        n_shut++; shut_cyc = cyc;
        chk("flush_done", 64'(flush_done), 64'd1);
        flush = 1'b0;
      end
      if (flush_req > 0 && outstanding && nreq == flush_req && !flush_up) begin
        flush = 1'b1; flush_up = 1;
      end

      mem_resp_valid = 1'b0;
      mem_resp_data  = rand64();
      if (outstanding) begin
        if (resp_wait == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = pte_of(pend_lvl, fault_lvl);
          outstanding    = 0;
          if (flush_up && flush_resp_cyc < 0) flush_resp_cyc = cyc;
        end else begin
          resp_wait--;
        end
      end

      mem_req_ready = 1'b0;
      miss = 1'b0;
      if (mem_req_valid) begin
        miss    = 1'($urandom);
        miss_va = rand64();
        if (nreq >= LEVELS) begin
          chk("req_extra", 64'(nreq), 64'(LEVELS - 1));
        end else begin
          if (!in_req) begin
            in_req = 1; stall_left = stall;
            lvl  = LEVELS - 1 - nreq;
            base = (nreq == 0) ? root : {ppn_tab[lvl + 1], 12'h000};
            exp_addr = base + (((va >> (SPAGE + SIDX * lvl)) & 64'h1FF) << 3);
            chk("req_addr", mem_req_addr, exp_addr);
          end else begin
            chk("req_addr_hold", mem_req_addr, exp_addr);
          end
          if (stall_left == 0) begin
            mem_req_ready = 1'b1; in_req = 0; outstanding = 1;
            resp_wait = rdelay; pend_lvl = lvl; nreq++;
          end else begin
            stall_left--;
          end
        end
      end

      rst = (cyc == rst_at);
      if (rst) nreq_at_rst = nreq;
      step();
      cyc++;
    end
    rst = 1'b0; miss = 1'b0; flush = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;

    if (rst_at >= 0) begin
      chk("rst_no_ins", 64'(n_ins), 64'd0);
      chk("rst_no_fault", 64'(n_flt), 64'd0);
      chk("rst_no_req", 64'(nreq), 64'(nreq_at_rst));
    end else if (flush_req > 0) begin
      chk("fl_no_ins", 64'(n_ins), 64'd0);
      chk("fl_no_fault", 64'(n_flt), 64'd0);
      chk("fl_shut_cnt", 64'(n_shut), 64'd1);
      chk("fl_shut_cyc", 64'(shut_cyc), 64'(flush_resp_cyc + 1));
      chk("fl_nreq", 64'(nreq), 64'(flush_req));
    end else if (fault_lvl >= 0) begin
      chk("flt_cnt", 64'(n_flt), 64'd1);
      chk("flt_cyc", 64'(flt_cyc), 64'(1 + (LEVELS - fault_lvl) * span));
      chk("flt_no_ins", 64'(n_ins), 64'd0);
      chk("flt_nreq", 64'(nreq), 64'(LEVELS - fault_lvl));
    end else begin
      chk("ins_cnt", 64'(n_ins), 64'd1);
      chk("ins_cyc", 64'(ins_cyc), 64'(1 + LEVELS * span));
      chk("ins_no_fault", 64'(n_flt), 64'd0);
      chk("ins_nreq", 64'(nreq), 64'(LEVELS));
    end
    if (rst_at < 0) chk("shut_only_on_flush", 64'(n_shut), 64'(flush_req > 0));
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  task automatic new_table();
    for (int i = 0; i < LEVELS; i++) ppn_tab[i] = {$urandom, 20'($urandom)};
  endtask

  initial begin
    int fl, st, rd, fq;
    rst = 1'b1; miss = 1'b0; flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    miss_va = '0; miss_pcid = '0; root_pa = '0; mem_resp_data = '0;
    step();
    step();
    chk("reset_pulses", {58'b0, mem_req_valid, insert_valid, shutdown, flush_done, fault, busy}, 64'd0);
    chk("reset_req_addr", mem_req_addr, 64'd0);
    chk("reset_ins_va", insert_va, 64'd0);
    chk("reset_ins_pa", insert_pa, 64'd0);
    chk("reset_ins_pcid", 64'(insert_pcid), 64'd0);
    rst = 1'b0;
    step();

    new_table(); ppn_tab[0] = 52'h77;
    run_walk(64'h1000, 64'h0000_0040_0123_4ABC, 12'd5, -1, 0, 0, 0, -1);
    chk("basic_pa", insert_pa, 64'h77ABC);
    new_table();
    run_walk(64'h1000, 64'h0000_0040_0123_4ABC, 12'd5, 2, 0, 0, 0, -1);
    new_table();
    run_walk(64'h1000, 64'h0000_0040_0123_4ABC, 12'd5, -1, 3, 0, 0, -1);
    new_table();
    run_walk(64'h2000, rand64(), 12'd9, -1, 0, 3, 2, -1);
    new_table();
    run_walk(64'h3000, rand64(), 12'd7, -1, 0, 0, 0, 4);

    miss = 1'b1; flush = 1'b1; miss_va = rand64(); root_pa = rand64();
    step();
    miss = 1'b0;
    chk("fm_shutdown", 64'(shutdown), 64'd1);
    chk("fm_flush_done", 64'(flush_done), 64'd1);
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fm_no_req", {62'b0, mem_req_valid, busy}, 64'd0);
    end

    flush = 1'b1;
    step();
    chk("idle_flush", {62'b0, shutdown, flush_done}, 64'd3);
    flush = 1'b0;
    step();
    chk("idle_flush_once", 64'(shutdown), 64'd0);

    for (int t = 0; t < 24; t++) begin
      new_table();
      fl = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, LEVELS - 1));
      st = $urandom_range(0, 2);
      rd = $urandom_range(0, 2);
      fq = 0;
      if (fl < 0 && $urandom_range(0, 3) == 0) fq = $urandom_range(1, LEVELS);
      run_walk(rand64(), rand64(), 12'($urandom), fl, st, rd, fq, -1);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
